// File: rtl/writeback_stage_p.sv
// Writeback stage: result select, load lane extraction and extension, load stall,
// and a registered commit stage that drives the register-file write port.
module writeback_stage_p #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ValidW,
  input  logic                RegWriteW,
  input  logic [REG_AW-1:0]   RdW,
  input  logic [1:0]          ResultSrcW,
  input  logic [1:0]          LoadSizeW,
  input  logic                LoadUnsignedW,
  input  logic [XLEN-1:0]     ALU_ResultW,
  input  logic [XLEN-1:0]     ReadDataW,
  input  logic [XLEN-1:0]     PCPlus4W,
  input  logic [XLEN-1:0]     ImmExtW,
  input  logic                o_p_waitrequest,
  output logic                StallW,
  output logic [XLEN-1:0]     ResultW,
  output logic [REG_AW-1:0]   RdC,
  output logic                RegWriteC,
  output logic [RETIRE_W-1:0] RetireCount
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic [OFF_W-1:0]    off_m;
  logic [7:0]          lane_bits;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     lane_mask;
  logic [XLEN-1:0]     sign_bit;
  logic                lane_neg;
  logic [XLEN-1:0]     load_data;
  logic [XLEN-1:0]     result_next;
  logic                commit;

  logic [XLEN-1:0]     result_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic                we_reg;
  logic [RETIRE_W-1:0] retire_reg;

  // Misaligned accesses are not trapped: low offset bits below the access size are dropped.
  always_comb begin
    off_m     = ALU_ResultW[OFF_W-1:0];
    lane_bits = 8'd8;
    case (LoadSizeW)
      2'b00: lane_bits = 8'd8;
      2'b01: begin
        off_m[0]  = 1'b0;
        lane_bits = 8'd16;
      end
      2'b10: begin
        off_m[1:0] = 2'b00;
        lane_bits  = 8'd32;
      end
      default: begin
        if (XLEN == 64) begin
          off_m     = '0;
          lane_bits = 8'd64;
        end else begin
          off_m[1:0] = 2'b00;
          lane_bits  = 8'd32;
        end
      end
    endcase
  end

  // Lane is shifted down to bit 0, then masked and sign- or zero-filled above its width.
  assign shifted   = ReadDataW >> {off_m, 3'b000};
  assign lane_mask = {XLEN{1'b1}} >> (8'(XLEN) - lane_bits);
  assign sign_bit  = lane_mask ^ (lane_mask >> 1);
  assign lane_neg  = ~LoadUnsignedW & (|(shifted & sign_bit));
  assign load_data = (shifted & lane_mask) | (lane_neg ? ~lane_mask : '0);

  always_comb begin
    result_next = ALU_ResultW;
    case (ResultSrcW)
      2'b00:   result_next = ALU_ResultW;
      2'b01:   result_next = load_data;
      2'b10:   result_next = PCPlus4W;
      default: result_next = ImmExtW;
    endcase
  end

  assign StallW = ValidW & (ResultSrcW == 2'b01) & o_p_waitrequest;
  assign commit = ValidW & ~StallW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg <= '0;
      rd_reg     <= '0;
      we_reg     <= 1'b0;
      retire_reg <= '0;
    end else begin
      we_reg <= commit & RegWriteW & (RdW != '0);
      if (commit) begin
        result_reg <= result_next;
        rd_reg     <= RdW;
        retire_reg <= retire_reg + RETIRE_W'(1);
      end
    end
  end

  assign ResultW     = result_reg;
  assign RdC         = rd_reg;
  assign RegWriteC   = we_reg;
  assign RetireCount = retire_reg;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed bench for writeback_stage_p (XLEN=32, RETIRE_W=4): vector table plus
// hand sequences for stalls, counter wrap and asynchronous reset.
module tb_writeback_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidW, RegWriteW, LoadUnsignedW, o_p_waitrequest;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW, LoadSizeW;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ImmExtW;
  logic        StallW, RegWriteC;
  logic [31:0] ResultW;
  logic [4:0]  RdC;
  logic [3:0]  RetireCount;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt = 4'd0;

  writeback_stage_p #(.XLEN(32), .REG_AW(5), .RETIRE_W(4)) dut (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultSrcW(ResultSrcW), .LoadSizeW(LoadSizeW), .LoadUnsignedW(LoadUnsignedW),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .ImmExtW(ImmExtW), .o_p_waitrequest(o_p_waitrequest), .StallW(StallW),
    .ResultW(ResultW), .RdC(RdC), .RegWriteC(RegWriteC), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw;
    logic [4:0]  rd;
    logic [1:0]  src, sz;
    logic        uns;
    logic [31:0] alu, rdat, pc4, imm;
    logic        wt;
    logic        e_stall, e_we;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic wt);
    ValidW = v; RegWriteW = rw; RdW = rd; ResultSrcW = src; LoadSizeW = sz;
    LoadUnsignedW = uns; ALU_ResultW = alu; ReadDataW = rdat; o_p_waitrequest = wt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          v     rw    rd     src    sz     uns   alu           rdat          pc4           imm           wt    stall we    res           rd
    vecs[0]  = '{1'b1,1'b1,5'd5, 2'b00,2'b00,1'b0,32'h0000_1234,32'h0,       32'h0,       32'h0,       1'b0,1'b0,1'b1,32'h0000_1234,5'd5};
    vecs[1]  = '{1'b1,1'b1,5'd6, 2'b01,2'b00,1'b0,32'h0000_0002,32'h1180_3344,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'hFFFF_FF80,5'd6};
    vecs[2]  = '{1'b1,1'b1,5'd6, 2'b01,2'b00,1'b1,32'h0000_0002,32'h1180_3344,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'h0000_0080,5'd6};
    vecs[3]  = '{1'b1,1'b1,5'd7, 2'b01,2'b01,1'b0,32'h0000_0002,32'h8011_3344,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'hFFFF_8011,5'd7};
    vecs[4]  = '{1'b1,1'b1,5'd7, 2'b01,2'b01,1'b1,32'h0000_0003,32'h8011_3344,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'h0000_8011,5'd7};
    vecs[5]  = '{1'b1,1'b1,5'd8, 2'b01,2'b10,1'b0,32'h0000_0001,32'hDEAD_BEEF,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'hDEAD_BEEF,5'd8};
    vecs[6]  = '{1'b1,1'b1,5'd8, 2'b01,2'b11,1'b1,32'h0000_0007,32'hCAFE_F00D,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'hCAFE_F00D,5'd8};
    vecs[7]  = '{1'b1,1'b1,5'd9, 2'b01,2'b00,1'b0,32'h0000_0003,32'h7F00_0000,32'h0,       32'h0,       1'b0,1'b0,1'b1,32'h0000_007F,5'd9};
    vecs[8]  = '{1'b1,1'b1,5'd7, 2'b00,2'b00,1'b0,32'h0000_0055,32'h0,       32'h0,       32'h0,       1'b1,1'b0,1'b1,32'h0000_0055,5'd7};
    vecs[9]  = '{1'b1,1'b1,5'd0, 2'b00,2'b00,1'b0,32'h0000_0099,32'h0,       32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0000_0099,5'd0};
    vecs[10] = '{1'b1,1'b0,5'd3, 2'b10,2'b00,1'b0,32'h0000_0000,32'h0,       32'h0000_0104,32'h0,       1'b0,1'b0,1'b0,32'h0000_0104,5'd3};
    vecs[11] = '{1'b1,1'b1,5'd1, 2'b10,2'b00,1'b0,32'h0000_0000,32'h0,       32'h0000_0104,32'hABCD_E000,1'b0,1'b0,1'b1,32'h0000_0104,5'd1};
    vecs[12] = '{1'b1,1'b1,5'd2, 2'b11,2'b00,1'b0,32'h0000_0000,32'h0,       32'h0000_0104,32'hABCD_E000,1'b0,1'b0,1'b1,32'hABCD_E000,5'd2};
    vecs[13] = '{1'b0,1'b1,5'd9, 2'b00,2'b00,1'b0,32'h0000_0777,32'h0,       32'h0,       32'h0,       1'b0,1'b0,1'b0,32'hABCD_E000,5'd2};
    vecs[14] = '{1'b0,1'b1,5'd9, 2'b01,2'b00,1'b0,32'h0000_0001,32'h1234_5678,32'h0,       32'h0,       1'b1,1'b0,1'b0,32'hABCD_E000,5'd2};

    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    PCPlus4W = 32'h0; ImmExtW = 32'h0;
    #12;
    check("reset_result", ResultW, 32'h0);
    check("reset_rd", {27'd0, RdC}, 32'h0);
    check("reset_we", {31'd0, RegWriteC}, 32'h0);
    check("reset_cnt", {28'd0, RetireCount}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].sz, vecs[i].uns,
            vecs[i].alu, vecs[i].rdat, vecs[i].wt);
      PCPlus4W = vecs[i].pc4; ImmExtW = vecs[i].imm;
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, StallW}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      if (vecs[i].v && !vecs[i].e_stall) exp_cnt = exp_cnt + 4'd1;
      check($sformatf("v%0d_result", i), ResultW, vecs[i].e_res);
      check($sformatf("v%0d_rd", i), {27'd0, RdC}, {27'd0, vecs[i].e_rd});
      check($sformatf("v%0d_we", i), {31'd0, RegWriteC}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d_cnt", i), {28'd0, RetireCount}, {28'd0, exp_cnt});
      $display("vec %0d: src=%0d res=0x%08h we=%0d cnt=%0d", i, ResultSrcW, ResultW, RegWriteC, RetireCount);
    end

    // Load held by waitrequest for three cycles, then commits with the final cycle's data.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd12, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0000_0012, 1'b1);
      #1;
      check($sformatf("stall%0d_stallw", c), {31'd0, StallW}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_we", c), {31'd0, RegWriteC}, 32'd0);
      check($sformatf("stall%0d_cnt", c), {28'd0, RetireCount}, {28'd0, exp_cnt});
      $display("stall cycle %0d: stall=%0d we=%0d cnt=%0d", c, StallW, RegWriteC, RetireCount);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0000_00A5, 1'b0);
    #1;
    check("release_stallw", {31'd0, StallW}, 32'd0);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 4'd1;
    check("release_result", ResultW, 32'hFFFF_FFA5);
    check("release_rd", {27'd0, RdC}, 32'd12);
    check("release_we", {31'd0, RegWriteC}, 32'd1);
    check("release_cnt", {28'd0, RetireCount}, {28'd0, exp_cnt});
    $display("stall release: res=0x%08h we=%0d cnt=%0d", ResultW, RegWriteC, RetireCount);

    // Commit until the counter sits at all-ones, then once more to wrap.
    for (int n = 0; n < 20 && exp_cnt != 4'hF; n++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 4'd1;
    end
    check("cnt_allones", {28'd0, RetireCount}, 32'hF);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd4, 2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    ImmExtW = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    check("cnt_wrap", {28'd0, RetireCount}, 32'h0);
    check("wrap_result", ResultW, 32'h0000_5A5A);
    $display("wrap: cnt=%0d res=0x%08h", RetireCount, ResultW);

    // Asynchronous reset in the middle of a stalled load, no clock edge in between.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd13, 2'b01, 2'b10, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", ResultW, 32'h0);
    check("arst_rd", {27'd0, RdC}, 32'h0);
    check("arst_we", {31'd0, RegWriteC}, 32'h0);
    check("arst_cnt", {28'd0, RetireCount}, 32'h0);
    $display("async reset: res=0x%08h rd=%0d we=%0d cnt=%0d", ResultW, RdC, RegWriteC, RetireCount);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 5'd13, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_we", {31'd0, RegWriteC}, 32'h0);
    check("post_rst_cnt", {28'd0, RetireCount}, 32'h0);
    check("post_rst_result", ResultW, 32'h0);
    $display("after reset idle: res=0x%08h we=%0d cnt=%0d", ResultW, RegWriteC, RetireCount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
